// File: rtl/crypt_pkg.sv
// Shared constants for the crypt_ctrl block-cipher sequencer: FSM state
// encodings, status bit positions and the default round count.
package crypt_pkg;
  localparam int ROUNDS_DEF = 16;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_KEY0   = 4'd1;
  localparam logic [3:0] S_KEY1   = 4'd2;
  localparam logic [3:0] S_FETCH0 = 4'd3;
  localparam logic [3:0] S_FETCH1 = 4'd4;
  localparam logic [3:0] S_LOAD   = 4'd5;
  localparam logic [3:0] S_ROUND  = 4'd6;
  localparam logic [3:0] S_STORE0 = 4'd7;
  localparam logic [3:0] S_STORE1 = 4'd8;

  localparam int ST_BUSY  = 0;
  localparam int ST_KEYV  = 1;
  localparam int ST_MODE  = 2;
  localparam int ST_OVR   = 3;
  localparam int ST_CONF  = 4;
  localparam int ST_NOKEY = 5;
endpackage

// File: rtl/word_pack.sv
// Assembles two FIFO pops into one double-width register: the first pop
// lands in the upper half, the second in the lower half. Holds otherwise.
module word_pack #(
  parameter int WORD_W = 32
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                en,
  input  logic                lower,
  input  logic [WORD_W-1:0]   word,
  output logic [2*WORD_W-1:0] data
);
  logic [2*WORD_W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (en) begin
      if (lower) data_d[WORD_W-1:0]        = word;
      else       data_d[2*WORD_W-1:WORD_W] = word;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) data_q <= '0;
    else        data_q <= data_d;
  end

  assign data = data_q;
endmodule

// File: rtl/crypt_ctrl.sv
// Sequencer between receive/transmit word FIFOs and an external round
// datapath: loads keys, fetches blocks, steps rounds, stores results.
module crypt_ctrl
  import crypt_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEF,
  parameter int WORD_W = 32
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                is_encrypt_pulse,
  input  logic                is_decrypt_pulse,
  input  logic                key_in,
  input  logic                status_clr,
  input  logic                rcv_fifo_empty,
  input  logic [WORD_W-1:0]   rcv_data,
  output logic                rcv_deq,
  input  logic                tx_fifo_full,
  output logic                tx_enq,
  output logic [WORD_W-1:0]   tx_data,
  output logic                key_load,
  output logic [2*WORD_W-1:0] key_data,
  output logic                dp_load,
  output logic [2*WORD_W-1:0] dp_block,
  output logic                dp_step,
  output logic [3:0]          dp_round,
  output logic                dp_decrypt,
  input  logic [2*WORD_W-1:0] dp_result,
  output logic [7:0]          status
);
  localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);

  logic [3:0] state_q, state_d, rnd_q, rnd_d;
  logic       key_valid_q, key_valid_d, mode_q, mode_d, key_load_q, key_load_d;
  logic       no_key_q, no_key_d, conflict_q, conflict_d, overrun_q, overrun_d;
  logic       set_nokey, set_conf, set_ovr;
  logic       fetching, pop, push, any_pulse, busy;

  assign busy      = (state_q != S_IDLE);
  assign any_pulse = is_encrypt_pulse | is_decrypt_pulse;
  assign fetching  = (state_q == S_KEY0) | (state_q == S_KEY1) |
                     (state_q == S_FETCH0) | (state_q == S_FETCH1);
  assign pop       = fetching & ~rcv_fifo_empty;
  assign push      = ((state_q == S_STORE0) | (state_q == S_STORE1)) & ~tx_fifo_full;

  word_pack #(.WORD_W(WORD_W)) u_key_pack (
    .HCLK(HCLK), .HRESET(HRESET),
    .en(pop & ((state_q == S_KEY0) | (state_q == S_KEY1))),
    .lower(state_q == S_KEY1), .word(rcv_data), .data(key_data)
  );

  word_pack #(.WORD_W(WORD_W)) u_blk_pack (
    .HCLK(HCLK), .HRESET(HRESET),
    .en(pop & ((state_q == S_FETCH0) | (state_q == S_FETCH1))),
    .lower(state_q == S_FETCH1), .word(rcv_data), .data(dp_block)
  );

  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    key_valid_d = key_valid_q;
    mode_d      = mode_q;
    key_load_d  = 1'b0;
    set_nokey   = 1'b0;
    set_conf    = 1'b0;
    set_ovr     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // key_in has priority; a pulse arriving alongside it is dropped
        if (key_in) begin
          state_d = S_KEY0;
          set_ovr = any_pulse;
        end else if (is_encrypt_pulse && is_decrypt_pulse) begin
          set_conf = 1'b1;
        end else if (any_pulse) begin
          if (key_valid_q) begin
            state_d = S_FETCH0;
            mode_d  = is_decrypt_pulse;
          end else begin
            set_nokey = 1'b1;
          end
        end
      end
      S_KEY0:   if (pop) state_d = S_KEY1;
      S_KEY1: if (pop) begin
        state_d     = S_IDLE;
        key_load_d  = 1'b1;
        key_valid_d = 1'b1;
      end
      S_FETCH0: if (pop) state_d = S_FETCH1;
      S_FETCH1: if (pop) state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_ROUND;
        rnd_d   = 4'd0;
      end
      S_ROUND: begin
        if (rnd_q == LAST_RND) begin
          rnd_d   = 4'd0;
          state_d = S_STORE0;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      S_STORE0: if (push) state_d = S_STORE1;
      S_STORE1: if (push) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (busy && (any_pulse || key_in)) set_ovr = 1'b1;
    // set events win over a same-cycle clear
    no_key_d   = (no_key_q   & ~status_clr) | set_nokey;
    conflict_d = (conflict_q & ~status_clr) | set_conf;
    overrun_d  = (overrun_q  & ~status_clr) | set_ovr;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      rnd_q       <= 4'd0;
      key_valid_q <= 1'b0;
      mode_q      <= 1'b0;
      key_load_q  <= 1'b0;
      no_key_q    <= 1'b0;
      conflict_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      key_valid_q <= key_valid_d;
      mode_q      <= mode_d;
      key_load_q  <= key_load_d;
      no_key_q    <= no_key_d;
      conflict_q  <= conflict_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    tx_data = '0;
    if (state_q == S_STORE0)      tx_data = dp_result[2*WORD_W-1:WORD_W];
    else if (state_q == S_STORE1) tx_data = dp_result[WORD_W-1:0];
    status           = 8'h00;
    status[ST_BUSY]  = busy;
    status[ST_KEYV]  = key_valid_q;
    status[ST_MODE]  = mode_q;
    status[ST_OVR]   = overrun_q;
    status[ST_CONF]  = conflict_q;
    status[ST_NOKEY] = no_key_q;
  end

  assign rcv_deq    = pop;
  assign tx_enq     = push;
  assign key_load   = key_load_q;
  assign dp_load    = (state_q == S_LOAD);
  assign dp_step    = (state_q == S_ROUND);
  assign dp_round   = mode_q ? (LAST_RND - rnd_q) : rnd_q;
  assign dp_decrypt = mode_q;
endmodule

// File: tb/tb_crypt_ctrl.sv
// Bench for crypt_ctrl: queue-based FIFOs, a toy round datapath and a
// transaction-level reference for results, timing and status.
module tb_crypt_ctrl;
  localparam int R = 16;
  localparam int W = 32;

  logic HCLK = 1'b0, HRESET;
  logic is_encrypt_pulse, is_decrypt_pulse, key_in, status_clr;
  logic rcv_fifo_empty, rcv_deq, tx_fifo_full, tx_enq;
  logic [W-1:0] rcv_data, tx_data;
  logic key_load, dp_load, dp_step, dp_decrypt;
  logic [2*W-1:0] key_data, dp_block, dp_result;
  logic [3:0] dp_round;
  logic [7:0] status;

  crypt_ctrl #(.ROUNDS(R), .WORD_W(W)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .is_encrypt_pulse(is_encrypt_pulse), .is_decrypt_pulse(is_decrypt_pulse),
    .key_in(key_in), .status_clr(status_clr),
    .rcv_fifo_empty(rcv_fifo_empty), .rcv_data(rcv_data), .rcv_deq(rcv_deq),
    .tx_fifo_full(tx_fifo_full), .tx_enq(tx_enq), .tx_data(tx_data),
    .key_load(key_load), .key_data(key_data),
    .dp_load(dp_load), .dp_block(dp_block), .dp_step(dp_step),
    .dp_round(dp_round), .dp_decrypt(dp_decrypt), .dp_result(dp_result),
    .status(status)
  );

  always #5 HCLK = ~HCLK;

  int nchk = 0, nerr = 0, cyc = 0;
  logic [W-1:0] rq[$];
  logic [W-1:0] txw[$];
  int txc[$];
  int rnds[$];
  int load_cyc, last_step, step_cnt, kl_cnt, deq_cnt, load_cnt, dec_ones;
  int late_dly = 0, txf_from = -1, txf_to = -1, rst_at_step = -1, xn;
  logic [W-1:0] late_word;
  logic [63:0] st = '0, force_val = '0, cur_key = '0, key_at_load, blk_at_load;
  bit force_res = 0, rnd_stall = 0, cur_mode = 0, cur_kv = 0;
  logic s_busy, s_deq, s_enq, s_load, s_step, s_kl;
  logic [7:0] s_status;
  logic [63:0] s_key, s_blk;
  logic [3:0] s_rnd;
  logic [W-1:0] s_txd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] fdp(logic [63:0] s, logic [63:0] k, logic [3:0] r);
    return {s[62:0], s[63]} ^ k ^ ({60'b0, r} * 64'h9E3779B97F4A7C15);
  endfunction

  function automatic logic [63:0] ref_run(logic [63:0] blk, logic [63:0] k, bit dec);
    logic [63:0] s = blk;
    for (int i = 0; i < R; i++) s = fdp(s, k, dec ? 4'(R - 1 - i) : 4'(i));
    return s;
  endfunction

  function automatic logic [7:0] stat(bit nk, bit cf, bit ov, bit md, bit kv);
    return {2'b00, nk, cf, ov, md, kv, 1'b0};
  endfunction

  task automatic clr_mon();
    txw.delete(); txc.delete(); rnds.delete();
    load_cyc = -1; last_step = -1; step_cnt = 0; kl_cnt = 0;
    deq_cnt = 0; load_cnt = 0; dec_ones = 0;
  endtask

  // one clock cycle: drive pulses, sample mid-cycle, then advance the models
  task automatic step(input bit e, input bit d, input bit k, input bit c);
    is_encrypt_pulse = e; is_decrypt_pulse = d; key_in = k; status_clr = c;
    @(negedge HCLK);
    s_busy = status[0]; s_status = status; s_deq = rcv_deq; s_enq = tx_enq;
    s_load = dp_load; s_step = dp_step; s_kl = key_load; s_key = key_data;
    s_blk = dp_block; s_rnd = dp_round; s_txd = tx_data;
    if (s_kl) begin kl_cnt++; key_at_load = s_key; end
    if (s_load) begin load_cnt++; load_cyc = cyc; blk_at_load = s_blk; end
    if (s_step) begin
      step_cnt++; last_step = cyc; rnds.push_back(int'(s_rnd));
      if (dp_decrypt) dec_ones++;
    end
    if (s_enq) begin txw.push_back(s_txd); txc.push_back(cyc); end
    if (s_deq) deq_cnt++;
    if (s_step && step_cnt == rst_at_step) HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    if (s_deq && rq.size() > 0) void'(rq.pop_front());
    if (s_load) st = s_blk;
    else if (s_step) st = fdp(st, s_key, s_rnd);
    if (late_dly > 0 && rq.size() == 0) begin
      late_dly--;
      if (late_dly == 0) rq.push_back(late_word);
    end
    cyc++;
    rcv_fifo_empty = (rq.size() == 0) || (rnd_stall && $urandom_range(0, 3) == 0);
    rcv_data = (rq.size() > 0) ? rq[0] : '0;
    tx_fifo_full = (cyc >= txf_from && cyc <= txf_to) || (rnd_stall && $urandom_range(0, 3) == 0);
    dp_result = force_res ? force_val : st;
    is_encrypt_pulse = 0; is_decrypt_pulse = 0; key_in = 0; status_clr = 0;
  endtask

  task automatic run_idle();
    bit done = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      step(0, 0, 0, 0);
      if (!s_busy) done = 1;
    end
    chk("timeout", 64'(done), 64'd1);
  endtask

  // one block transaction with generic result/round/strobe checks
  task automatic xact(input bit dec, input logic [63:0] blk, input bit fetch_stall, input bit tx_stall);
    logic [63:0] exp;
    int bad = 0;
    clr_mon();
    rq.push_back(blk[63:32]);
    if (fetch_stall) begin late_word = blk[31:0]; late_dly = 6; end
    else rq.push_back(blk[31:0]);
    xn = cyc;
    if (tx_stall) begin txf_from = xn + 4 + R; txf_to = xn + 6 + R; end
    step(!dec, dec, 0, 0);
    run_idle();
    txf_from = -1; txf_to = -1;
    cur_mode = dec;
    exp = force_res ? force_val : ref_run(blk, cur_key, dec);
    chk("tx_count", 64'(txw.size()), 64'd2);
    if (txw.size() == 2) begin
      chk("tx_hi", 64'(txw[0]), 64'(exp[63:32]));
      chk("tx_lo", 64'(txw[1]), 64'(exp[31:0]));
    end
    chk("step_cnt", 64'(step_cnt), 64'(R));
    chk("load_cnt", 64'(load_cnt), 64'd1);
    chk("deq_cnt", 64'(deq_cnt), 64'd2);
    chk("dp_block", blk_at_load, blk);
    for (int i = 0; i < rnds.size(); i++)
      if (rnds[i] != (dec ? R - 1 - i : i)) bad++;
    chk("round_order", 64'(bad), 64'd0);
    chk("dp_decrypt", 64'(dec_ones), dec ? 64'(R) : 64'd0);
  endtask

  initial begin
    logic [63:0] blk, k2;
    HRESET = 1; is_encrypt_pulse = 0; is_decrypt_pulse = 0; key_in = 0; status_clr = 0;
    rcv_fifo_empty = 1; rcv_data = '0; tx_fifo_full = 0; dp_result = '0;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 0;
    clr_mon();
    step(0, 0, 0, 0);
    chk("rst_status", 64'(s_status), 64'h00);
    chk("rst_key", s_key, 64'd0);
    chk("rst_blk", s_blk, 64'd0);
    chk("rst_txd", 64'(s_txd), 64'd0);
    chk("rst_strobes", 64'({s_deq, s_enq, s_load, s_step, s_kl}), 64'd0);
    chk("rst_round", 64'(s_rnd), 64'd0);

    // encrypt with no key: words wait in the FIFO untouched
    rq.push_back(32'h01234567); rq.push_back(32'h89ABCDEF);
    clr_mon();
    step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("nokey_status", 64'(s_status), 64'h20);
    chk("nokey_deq", 64'(deq_cnt), 64'd0);
    step(0, 0, 0, 1); step(0, 0, 0, 0);
    chk("clr_status", 64'(s_status), 64'h00);

    // key load from the queued words
    clr_mon();
    step(0, 0, 1, 0);
    run_idle();
    cur_key = 64'h0123456789ABCDEF; cur_kv = 1;
    chk("key_load_cnt", 64'(kl_cnt), 64'd1);
    chk("key_data", key_at_load, cur_key);
    step(0, 0, 0, 0);
    chk("key_status", 64'(s_status), 64'(stat(0, 0, 0, 0, 1)));
    chk("key_hold", s_key, cur_key);

    // zero-stall encrypt: exact latency
    xact(0, {$urandom, $urandom}, 0, 0);
    chk("lat_load", 64'(load_cyc), 64'(xn + 3));
    chk("lat_last_step", 64'(last_step), 64'(xn + 3 + R));
    if (txc.size() == 2) begin
      chk("lat_tx0", 64'(txc[0]), 64'(xn + 4 + R));
      chk("lat_tx1", 64'(txc[1]), 64'(xn + 5 + R));
    end

    // decrypt with 5 starved cycles in FETCH1
    xact(1, {$urandom, $urandom}, 1, 0);
    chk("stall_load", 64'(load_cyc), 64'(xn + 8));
    chk("mode_status", 64'(s_status), 64'(stat(0, 0, 0, 1, 1)));

    // tx full for 3 cycles in STORE0
    force_res = 1; force_val = 64'hAAAAAAAA_55555555;
    xact(0, {$urandom, $urandom}, 0, 1);
    force_res = 0;
    if (txc.size() == 2) begin
      chk("txstall_tx0", 64'(txc[0]), 64'(xn + 7 + R));
      chk("txstall_tx1", 64'(txc[1]), 64'(xn + 8 + R));
    end

    // simultaneous encrypt+decrypt
    clr_mon();
    step(1, 1, 0, 0); step(0, 0, 0, 0);
    chk("conflict_status", 64'(s_status), 64'(stat(0, 1, 0, 0, 1)));
    chk("conflict_deq", 64'(deq_cnt), 64'd0);

    // key_in while busy -> overrun, block still completes
    blk = {$urandom, $urandom};
    rq.push_back(blk[63:32]); rq.push_back(blk[31:0]);
    clr_mon();
    step(1, 0, 0, 0); step(0, 0, 1, 0);
    run_idle();
    chk("ovr_tx_count", 64'(txw.size()), 64'd2);
    chk("ovr_key_loads", 64'(kl_cnt), 64'd0);
    chk("ovr_status", 64'(s_status), 64'(stat(0, 1, 1, 0, 1)));
    step(1, 1, 0, 1); step(0, 0, 0, 0);
    chk("set_wins_clr", 64'(s_status), 64'(stat(0, 1, 0, 0, 1)));
    step(0, 0, 0, 1); step(0, 0, 0, 0);
    chk("clr_all", 64'(s_status), 64'(stat(0, 0, 0, 0, 1)));

    // key_in together with encrypt: key path wins, overrun set
    k2 = {$urandom, $urandom};
    rq.push_back(k2[63:32]); rq.push_back(k2[31:0]);
    clr_mon();
    step(1, 0, 1, 0);
    run_idle();
    cur_key = k2;
    chk("kin_enc_key", key_at_load, k2);
    chk("kin_enc_loads", 64'(load_cnt), 64'd0);
    step(0, 0, 0, 0);
    chk("kin_enc_status", 64'(s_status), 64'(stat(0, 0, 1, 0, 1)));
    step(0, 0, 0, 1);

    // randomized blocks with random FIFO back-pressure
    rnd_stall = 1;
    for (int t = 0; t < 12; t++) begin
      xact(1'($urandom_range(0, 1)), {$urandom, $urandom}, 0, 0);
      step(0, 0, 0, 0);
      chk("rnd_status", 64'(s_status), 64'(stat(0, 0, 0, cur_mode, 1)));
    end
    rnd_stall = 0;
    step(0, 0, 0, 0);

    // reset on the 8th round abandons the block
    blk = {$urandom, $urandom};
    rq.push_back(blk[63:32]); rq.push_back(blk[31:0]);
    clr_mon();
    rst_at_step = 8;
    step(1, 0, 0, 0);
    run_idle();
    rst_at_step = -1;
    chk("rstmid_steps", 64'(step_cnt), 64'd8);
    chk("rstmid_status", 64'(s_status), 64'h00);
    rq.push_back(32'hDEADBEEF); rq.push_back(32'hCAFEF00D);
    for (int i = 0; i < 30; i++) step(0, 0, 0, 0);
    chk("rstmid_no_tx", 64'(txw.size()), 64'd0);
    chk("rstmid_no_deq", 64'(deq_cnt), 64'd2);
    chk("rstmid_key", s_key, 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
